lsu: RTL and testbench

Load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the ALU result as the effective address for I_LOAD and S_TYPE instructions and runs a request/grant/response handshake with data memory. It aligns store data and byte enables, and sign- or zero-extends load data for writeback. It stalls the core while a memory access is outstanding.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_load_format.sv | 30 +++
 rtl/lsu.sv | 124 ++++++++++++
 tb/tb_lsu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: opcode encodings, access sizes,
// FSM states, byte-enable patterns and access legality helpers.
package lsu_pkg;

    // Opcode encodings shared with the core decoder
    typedef enum logic [6:0] {
        R_TYPE  = 7'b0110011,
        I_TYPE  = 7'b0010011,
        I_LOAD  = 7'b0000011,
        S_TYPE  = 7'b0100011,
        B_TYPE  = 7'b1100011,
        U_LUI   = 7'b0110111,
        U_AUIPC = 7'b0010111,
        J_JAL   = 7'b1101111,
        I_JALR  = 7'b1100111
    } all_opcodes;

    typedef enum logic [2:0] {
        MS_B  = 3'b000,
        MS_H  = 3'b001,
        MS_W  = 3'b010,
        MS_BU = 3'b100,
        MS_HU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic funct3_legal(input logic [2:0] funct3, input logic is_load);
        logic legal;
        legal = (funct3 == MS_B) || (funct3 == MS_H) || (funct3 == MS_W);
        if (is_load) begin
            legal = legal || (funct3 == MS_BU) || (funct3 == MS_HU);
        end
        return legal;
    endfunction

    // funct3[1:0] encodes the access size for every legal encoding
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        return ((funct3[1:0] == 2'b01) && addr_lo[0]) ||
               ((funct3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Load lane selection and sign/zero extension of the returned memory word.
module lsu_load_format
    import lsu_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] rdata,
    input  logic [1:0]           addr_lo,
    input  logic [2:0]           funct3,
    output logic [BUS_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*addr_lo +: 8];
    assign half_sel = rdata[16*addr_lo[1] +: 16];

    always_comb begin
        data = rdata;
        case (funct3)
            MS_B:    data = {{(BUS_WIDTH-8){byte_sel[7]}}, byte_sel};
            MS_BU:   data = {{(BUS_WIDTH-8){1'b0}}, byte_sel};
            MS_H:    data = {{(BUS_WIDTH-16){half_sel[15]}}, half_sel};
            MS_HU:   data = {{(BUS_WIDTH-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs the req/gnt/rvalid handshake with data memory,
// formats store lanes and byte enables, and stalls the core meanwhile.
module lsu
    import lsu_pkg::*;
#(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [BUS_WIDTH-1:0] addr_i,
    input  logic [BUS_WIDTH-1:0] store_data_i,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [BUS_WIDTH-1:0] mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [BUS_WIDTH-1:0] mem_wdata_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [BUS_WIDTH-1:0] mem_rdata_i,
    output logic                 stall_o,
    output logic                 done_o,
    output logic                 fault_o,
    output logic [BUS_WIDTH-1:0] load_data_o
);

    lsu_state_e state_q, state_d;

    logic                 is_load, is_store, start, access_fault;
    logic [1:0]           addr_lo_q;
    logic [2:0]           funct3_q;
    logic                 is_load_q, fault_q;
    logic                 mem_we_q;
    logic [BUS_WIDTH-1:0] mem_addr_q, mem_wdata_q, load_data_q, fmt_data;
    logic [3:0]           mem_be_q;

    function automatic logic [3:0] store_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   return BE_BYTE << addr_lo;
            2'b01:   return addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [BUS_WIDTH-1:0] store_wdata(input logic [2:0] funct3,
                                                          input logic [BUS_WIDTH-1:0] d);
        case (funct3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    assign is_load      = (opcode_i == I_LOAD);
    assign is_store     = (opcode_i == S_TYPE);
    assign start        = valid_i && (is_load || is_store) && (state_q == IDLE);
    assign access_fault = !funct3_legal(funct3_i, is_load) || misaligned(funct3_i, addr_i[1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = access_fault ? DONE : REQ;
            REQ:  if (mem_gnt_i) state_d = is_load_q ? RESP : DONE;
            RESP: if (mem_rvalid_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
            fault_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                fault_q   <= access_fault;
                addr_lo_q <= addr_i[1:0];
                funct3_q  <= funct3_i;
                is_load_q <= is_load;
                // Faulting accesses never reach the bus, so leave its outputs alone
                if (!access_fault) begin
                    mem_we_q    <= is_store;
                    mem_addr_q  <= {addr_i[BUS_WIDTH-1:2], 2'b00};
                    mem_be_q    <= store_be(funct3_i, addr_i[1:0]);
                    mem_wdata_q <= store_wdata(funct3_i, store_data_i);
                end
            end
            if ((state_q == RESP) && mem_rvalid_i) begin
                load_data_q <= fmt_data;
            end
        end
    end

    lsu_load_format #(
        .BUS_WIDTH(BUS_WIDTH)
    ) u_load_format (
        .rdata  (mem_rdata_i),
        .addr_lo(addr_lo_q),
        .funct3 (funct3_q),
        .data   (fmt_data)
    );

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign stall_o     = start || (state_q == REQ) || (state_q == RESP);
    assign done_o      = (state_q == DONE);
    assign fault_o     = (state_q == DONE) && fault_q;
    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_lsu.sv
// Randomized bench for lsu against a byte-lane reference model of the access rules.
module tb_lsu;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [31:0] addr_i = '0, store_data_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o, done_o, fault_o;
    logic [31:0] load_data_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] model_ld = '0;

    always #5 clk = ~clk;

    lsu #(.BUS_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .store_data_i(store_data_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .done_o(done_o), .fault_o(fault_o), .load_data_o(load_data_o)
    );

    function automatic bit exp_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int nb;
        bit legal;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        nb = 1 << f3[1:0];
        return !legal || ((a % nb) != 0);
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int nb, m;
        nb = 1 << f3[1:0];
        m = ((1 << nb) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int nb;
        nb = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v, mask;
        int nb;
        nb = 1 << f3[1:0];
        if (nb == 4) return rd;
        mask = (32'd1 << (8*nb)) - 32'd1;
        v = (rd >> (8*(a % 4))) & mask;
        if (!f3[2] && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // Drives one access from IDLE and plays the memory side; returns what it observed.
    task automatic run_access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd,
                              input int gw, input int rw, input bit noise,
                              output int done_cyc, output bit flt, output logic [31:0] ld,
                              output bit req_seen, output int req_cycles,
                              output logic [31:0] ao, output logic [3:0] beo,
                              output logic [31:0] wdo, output bit weo, output bit stable,
                              output bit stall0, output bit stall_done, output bit extra_done);
        bit in_resp;
        int resp_n, cyc;
        done_cyc = -1; flt = 0; ld = '0; req_seen = 0; req_cycles = 0;
        ao = '0; beo = '0; wdo = '0; weo = 0; stable = 1; stall_done = 0; extra_done = 0;
        in_resp = 0; resp_n = 0;
        valid_i = 1'b1; opcode_i = op; funct3_i = f3; addr_i = a; store_data_i = wd;
        mem_rdata_i = rd;
        #1 stall0 = stall_o;
        @(posedge clk); #1;
        valid_i = 1'b0;
        cyc = 1;
        while (cyc < 60) begin
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (done_o) begin
                done_cyc = cyc; flt = fault_o; ld = load_data_o; stall_done = stall_o;
                break;
            end
            if (in_resp) begin
                if (resp_n == rw) begin mem_rvalid_i = 1'b1; in_resp = 0; end
                resp_n++;
            end
            if (mem_req_o) begin
                if (!req_seen) begin
                    ao = mem_addr_o; beo = mem_be_o; wdo = mem_wdata_o; weo = mem_we_o;
                end else if (ao !== mem_addr_o || beo !== mem_be_o || wdo !== mem_wdata_o ||
                             weo !== mem_we_o) begin
                    stable = 0;
                end
                req_seen = 1;
                if (req_cycles == gw) begin
                    mem_gnt_i = 1'b1;
                    if (op == OP_LOAD) begin in_resp = 1; resp_n = 0; end
                end else if (noise) begin
                    mem_rvalid_i = 1'($urandom_range(0, 1));
                end
                req_cycles++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(posedge clk); #1;
        extra_done = done_o;
    endtask

    task automatic test_reset();
        logic [31:0] all_out;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        all_out = {mem_req_o, mem_we_o, mem_be_o, stall_o, done_o, fault_o} |
                  mem_addr_o | mem_wdata_o | load_data_o;
        vectors++; if (all_out !== 32'd0) begin miscompares++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++; if (stall_o !== 1'b0 || done_o !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got stall=%b done=%b want 0/0", stall_o, done_o); end
    endtask

    task automatic test_store_sb();
        int dc, rc; bit f, rs, we, st, s0, sd, xd; logic [31:0] ld, ao, wdo; logic [3:0] be;
        run_access(OP_STORE, 3'b000, 32'h1003, 32'h000000AB, 32'h0, 2, 0, 0,
                   dc, f, ld, rs, rc, ao, be, wdo, we, st, s0, sd, xd);
        vectors++; if (ao !== 32'h1000) begin miscompares++; $display("FAIL sb_addr: got %h want 00001000", ao); end
        vectors++; if (be !== 4'b1000) begin miscompares++; $display("FAIL sb_be: got %b want 1000", be); end
        vectors++; if (wdo !== 32'hABABABAB) begin miscompares++; $display("FAIL sb_wdata: got %h want abababab", wdo); end
        vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sb_we: got %b want 1", we); end
        vectors++; if (st !== 1'b1 || rc !== 3) begin miscompares++; $display("FAIL sb_hold: got stable=%b req_cycles=%0d want 1/3", st, rc); end
        vectors++; if (dc !== 4 || f !== 1'b0) begin miscompares++; $display("FAIL sb_done: got cycle=%0d fault=%b want 4/0", dc, f); end
        vectors++; if (s0 !== 1'b1 || sd !== 1'b0 || xd !== 1'b0) begin miscompares++; $display("FAIL sb_stall: got s0=%b sdone=%b extra=%b want 1/0/0", s0, sd, xd); end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] rds [4] = '{32'h12F45678, 32'h12F45678, 32'h80010000, 32'h80010000};
        logic [31:0] exps[4] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8001, 32'h00008001};
        int dc, rc; bit f, rs, we, st, s0, sd, xd; logic [31:0] ld, ao, wdo; logic [3:0] be;
        for (int i = 0; i < 4; i++) begin
            run_access(OP_LOAD, f3s[i], 32'h2002, 32'h0, rds[i], 0, 0, 0,
                       dc, f, ld, rs, rc, ao, be, wdo, we, st, s0, sd, xd);
            vectors++; if (ld !== exps[i]) begin miscompares++; $display("FAIL load_ext%0d: got %h want %h", i, ld, exps[i]); end
            vectors++; if (dc !== 3 || f !== 1'b0 || ao !== 32'h2000 || we !== 1'b0) begin miscompares++; $display("FAIL load_bus%0d: got cycle=%0d fault=%b addr=%h we=%b want 3/0/00002000/0", i, dc, f, ao, we); end
            vectors++; if (load_data_o !== exps[i]) begin miscompares++; $display("FAIL load_hold%0d: got %h want %h", i, load_data_o, exps[i]); end
        end
        model_ld = 32'h00008001;
    endtask

    task automatic test_fault();
        int dc, rc; bit f, rs, we, st, s0, sd, xd; logic [31:0] ld, ao, wdo; logic [3:0] be;
        run_access(OP_LOAD, 3'b010, 32'h3001, 32'h0, 32'hCAFEF00D, 0, 0, 0,
                   dc, f, ld, rs, rc, ao, be, wdo, we, st, s0, sd, xd);
        vectors++; if (dc !== 1 || f !== 1'b1) begin miscompares++; $display("FAIL lw_mis_done: got cycle=%0d fault=%b want 1/1", dc, f); end
        vectors++; if (rs !== 1'b0) begin miscompares++; $display("FAIL lw_mis_req: got req=%b want 0", rs); end
        vectors++; if (ld !== model_ld) begin miscompares++; $display("FAIL lw_mis_data: got %h want %h", ld, model_ld); end
        run_access(OP_STORE, 3'b011, 32'h4000, 32'h11223344, 32'h0, 0, 0, 0,
                   dc, f, ld, rs, rc, ao, be, wdo, we, st, s0, sd, xd);
        vectors++; if (dc !== 1 || f !== 1'b1 || rs !== 1'b0) begin miscompares++; $display("FAIL st_f3_011: got cycle=%0d fault=%b req=%b want 1/1/0", dc, f, rs); end
    endtask

    task automatic test_non_memory();
        bit bad;
        bad = 0;
        valid_i = 1'b1; opcode_i = OP_R; funct3_i = 3'b000; addr_i = 32'h10;
        #1;
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rtype_stall: got %b want 0", stall_o); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (mem_req_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b0) bad = 1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL rtype_idle: got activity=1 want 0"); end
        valid_i = 1'b0; opcode_i = '0;
    endtask

    task automatic test_reset_mid_resp();
        logic [31:0] all_out;
        bit bad;
        valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'b010; addr_i = 32'h5000;
        mem_rdata_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        valid_i = 1'b0; mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        vectors++; if (stall_o !== 1'b1 || mem_req_o !== 1'b0) begin miscompares++; $display("FAIL resp_state: got stall=%b req=%b want 1/0", stall_o, mem_req_o); end
        #2 rst = 1'b1;
        #1;
        all_out = {mem_req_o, mem_we_o, mem_be_o, stall_o, done_o, fault_o} |
                  mem_addr_o | mem_wdata_o | load_data_o;
        vectors++; if (all_out !== 32'd0) begin miscompares++; $display("FAIL rst_async: got %h want 0", all_out); end
        @(posedge clk); #1;
        rst = 1'b0; mem_rvalid_i = 1'b1;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (load_data_o !== 32'd0 || done_o !== 1'b0 || stall_o !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        vectors++; if (bad) begin miscompares++; $display("FAIL late_rvalid: got ld=%h done=%b want 0/0", load_data_o, done_o); end
        model_ld = '0;
    endtask

    task automatic test_random();
        int dc, rc, gw, rw, edc; bit f, rs, we, st, s0, sd, xd, ld_op, ef;
        logic [31:0] ld, ao, wdo, a, d, rd; logic [3:0] be; logic [2:0] f3;
        for (int n = 0; n < 60; n++) begin
            ld_op = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; d = $urandom; rd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                else if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            gw = $urandom_range(0, 3); rw = $urandom_range(0, 3);
            ef = exp_fault(ld_op, f3, a);
            edc = ef ? 1 : (ld_op ? 3 + gw + rw : 2 + gw);
            run_access(ld_op ? OP_LOAD : OP_STORE, f3, a, d, rd, gw, rw, 1,
                       dc, f, ld, rs, rc, ao, be, wdo, we, st, s0, sd, xd);
            if (!ef && ld_op) model_ld = exp_load(f3, a, rd);
            vectors++; if (dc !== edc || f !== ef || rs !== !ef) begin miscompares++; $display("FAIL rnd%0d_ctl: got cycle=%0d fault=%b req=%b want %0d/%b/%b", n, dc, f, rs, edc, ef, !ef); end
            vectors++; if (ld !== model_ld) begin miscompares++; $display("FAIL rnd%0d_ld: got %h want %h", n, ld, model_ld); end
            vectors++; if (s0 !== 1'b1 || sd !== 1'b0 || xd !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_stall: got s0=%b sdone=%b extra=%b want 1/0/0", n, s0, sd, xd); end
            if (!ef) begin
                vectors++; if (ao !== {a[31:2], 2'b00} || we !== !ld_op || st !== 1'b1 || rc !== gw + 1) begin miscompares++; $display("FAIL rnd%0d_bus: got addr=%h we=%b stable=%b reqc=%0d want %h/%b/1/%0d", n, ao, we, st, rc, {a[31:2], 2'b00}, !ld_op, gw + 1); end
                if (!ld_op) begin
                    vectors++; if (be !== exp_be(f3, a) || wdo !== exp_wdata(f3, d)) begin miscompares++; $display("FAIL rnd%0d_st: got be=%b wdata=%h want %b/%h", n, be, wdo, exp_be(f3, a), exp_wdata(f3, d)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_sb();
        test_load_extend();
        test_fault();
        test_non_memory();
        test_reset_mid_resp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
